tone_player: RTL and testbench

TONE_PLAYER -- requirements
Module: tone_player

---
 rtl/tone_pkg.sv | 14 +
 rtl/tone_divider.sv | 36 +++
 rtl/tone_player.sv | 127 ++++++++++++
 tb/tb_tone_player.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tone_pkg.sv
// Shared types and defaults for the tone player.
// The FSM state enum lives here so every file agrees on encoding.
package tone_pkg;

    localparam int CNT_W_DEF     = 17;
    localparam int GAP_TICKS_DEF = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        GAP  = 2'd2
    } state_t;

endpackage

// File: rtl/tone_divider.sv
// Square-wave generator: toggles audio_out every half_period cycles while enabled.
// Dropping enable clears the counter and forces the output low.
import tone_pkg::*;

module tone_divider #(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [CNT_W-1:0] half_period,
    output logic             audio_out
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] tone_cnt;
    logic             wrap;
    logic             silent;

    assign silent = (half_period == '0);
    assign wrap   = (tone_cnt == half_period - ONE);

    always_ff @(posedge clk) begin
        if (reset || !enable || silent) begin
            tone_cnt  <= '0;
            audio_out <= 1'b0;
        end else if (wrap) begin
            tone_cnt  <= '0;
            audio_out <= ~audio_out;
        end else begin
            tone_cnt  <= tone_cnt + ONE;
        end
    end

endmodule

// File: rtl/tone_player.sv
// Note sequencer: plays one tone per accepted note, then a silent gap, then pulses done.
// Optional TONE_PLAYER_ABORT_EN adds an abort input that drops PLAY/GAP back to IDLE.
import tone_pkg::*;

module tone_player #(
    parameter int CNT_W     = CNT_W_DEF,
    parameter int GAP_TICKS = GAP_TICKS_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [CNT_W-1:0] counter_in,
    input  logic             note_valid,
    output logic             note_ready,
    input  logic [CNT_W-1:0] note_half_period,
    input  logic [7:0]       note_dur,
`ifdef TONE_PLAYER_ABORT_EN
    input  logic             abort,
`endif
    output logic             audio_out,
    output logic             busy,
    output logic             done
);

    localparam logic [7:0] GAP_INIT = GAP_TICKS[7:0];

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] hp_q;
    logic [CNT_W-1:0] hp_n;
    logic [7:0]       dur_cnt;
    logic [7:0]       dur_n;
    logic [7:0]       gap_cnt;
    logic [7:0]       gap_n;
    logic             done_n;
    logic             tick;
    logic             accept;
    logic             tone_en;

    assign tick    = (counter_in == '1);
    assign accept  = note_valid && note_ready;
    assign busy    = (state != IDLE);
    assign tone_en = (state == PLAY) && (state_n == PLAY);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            hp_q       <= '0;
            dur_cnt    <= '0;
            gap_cnt    <= '0;
            note_ready <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            hp_q       <= hp_n;
            dur_cnt    <= dur_n;
            gap_cnt    <= gap_n;
            note_ready <= (state_n == IDLE);
            done       <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        hp_n    = hp_q;
        dur_n   = dur_cnt;
        gap_n   = gap_cnt;
        done_n  = 1'b0;
        unique case (state)
            IDLE: begin
                // Tick on the accept cycle is deliberately not counted.
                if (accept) begin
                    hp_n  = note_half_period;
                    dur_n = note_dur;
                    if (note_dur == 8'd0) begin
                        state_n = GAP;
                        gap_n   = GAP_INIT;
                    end else begin
                        state_n = PLAY;
                    end
                end
            end
            PLAY: begin
                if (tick) begin
                    dur_n = dur_cnt - 8'd1;
                    if (dur_cnt == 8'd1) begin
                        state_n = GAP;
                        gap_n   = GAP_INIT;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == 8'd0) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else if (tick) begin
                    gap_n = gap_cnt - 8'd1;
                    if (gap_cnt == 8'd1) begin
                        state_n = IDLE;
                        done_n  = 1'b1;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
`ifdef TONE_PLAYER_ABORT_EN
        if (abort && state != IDLE) begin
            state_n = IDLE;
            dur_n   = 8'd0;
            gap_n   = 8'd0;
            done_n  = 1'b0;
        end
`endif
    end

    tone_divider #(
        .CNT_W(CNT_W)
    ) u_div (
        .clk        (clk),
        .reset      (reset),
        .enable     (tone_en),
        .half_period(hp_q),
        .audio_out  (audio_out)
    );

endmodule

// File: tb/tb_tone_player.sv
// Scoreboard bench for tone_player: expected per-note results are queued at accept
// and checked by a monitor when done pulses.
module tb_tone_player;

    localparam int CW = 4;
    localparam int TP = 16;

    typedef struct {
        int busy_len;
        int rises;
        int hp;
    } exp_t;

    logic          clk;
    logic          reset;
    logic [CW-1:0] tcnt;
    logic          note_valid;
    logic          note_ready;
    logic [CW-1:0] note_half_period;
    logic [7:0]    note_dur;
    logic          audio_out;
    logic          busy;
    logic          done;
`ifdef TONE_PLAYER_ABORT_EN
    logic          abort;
`endif

    exp_t exp_q[$];
    int   checks;
    int   errors;
    int   done_cnt;
    int   pushed;

    tone_player #(
        .CNT_W    (CW),
        .GAP_TICKS(1)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .counter_in      (tcnt),
        .note_valid      (note_valid),
        .note_ready      (note_ready),
        .note_half_period(note_half_period),
        .note_dur        (note_dur),
`ifdef TONE_PLAYER_ABORT_EN
        .abort           (abort),
`endif
        .audio_out       (audio_out),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial tcnt = '0;
    always @(posedge clk) tcnt <= tcnt + 1'b1;

    // Cycles from accept edge to first tick edge after it.
    function automatic int first_tick(input int c);
        return (c == TP - 1) ? TP : (TP - 1 - c);
    endfunction

    function automatic int exp_busy(input int c, input int dur);
        return first_tick(c) + TP * dur;
    endfunction

    function automatic int exp_rises(input int c, input int hp, input int dur);
        int p;
        int n;
        if (hp == 0 || dur == 0) return 0;
        p = first_tick(c) + TP * (dur - 1);
        n = (p - 1) / hp;
        return (n + 1) / 2;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic send(input int hp, input int dur, input bit push,
                        input bit keep, output int c);
        int   n;
        exp_t e;
        note_valid       = 1'b1;
        note_half_period = hp[CW-1:0];
        note_dur         = dur[7:0];
        n = 0;
        c = 0;
        while (!note_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!note_ready) begin
            errors++;
            $display("FAIL accept_timeout got ready=0 expected ready=1");
            note_valid = 1'b0;
            return;
        end
        c = int'(tcnt);
        if (push) begin
            e.busy_len = exp_busy(c, dur);
            e.rises    = exp_rises(c, hp, dur);
            e.hp       = hp;
            exp_q.push_back(e);
            pushed++;
        end
        @(negedge clk);
        if (!keep) note_valid = 1'b0;
    endtask

    // Monitor: per-note busy length, rising-edge count and tone period.
    initial begin
        int   cyc;
        int   busy_len;
        int   rises;
        int   last_rise;
        bit   have_rise;
        bit   prev_audio;
        bit   prev_done;
        exp_t e;
        cyc = 0;
        busy_len = 0;
        rises = 0;
        last_rise = 0;
        have_rise = 0;
        prev_audio = 0;
        prev_done = 0;
        forever begin
            @(negedge clk);
            cyc++;
            chk("ready_busy_overlap", int'(note_ready && busy), 0);
            if (done) begin
                done_cnt++;
                chk("done_width", int'(prev_done), 0);
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL done_unexpected got done=1 expected done=0");
                end else begin
                    e = exp_q.pop_front();
                    chk("busy_len", busy_len, e.busy_len);
                    chk("rises", rises, e.rises);
                end
            end
            if (busy) begin
                busy_len++;
                if (audio_out && !prev_audio) begin
                    if (have_rise && exp_q.size() > 0)
                        chk("tone_period", cyc - last_rise, 2 * exp_q[0].hp);
                    rises++;
                    last_rise = cyc;
                    have_rise = 1;
                end
            end else begin
                busy_len = 0;
                rises = 0;
                have_rise = 0;
            end
            prev_audio = audio_out;
            prev_done  = done;
        end
    end

    initial begin
        int c;
        int n;
        checks = 0;
        errors = 0;
        done_cnt = 0;
        pushed = 0;
        reset = 1'b1;
        note_valid = 1'b0;
        note_half_period = '0;
        note_dur = '0;
`ifdef TONE_PLAYER_ABORT_EN
        abort = 1'b0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_audio", int'(audio_out), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(note_ready), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(note_ready), 1);

        send(4, 2, 1, 0, c);
        send(0, 3, 1, 0, c);
        send(10, 0, 1, 0, c);
        send(1, 1, 1, 0, c);

        // note_valid held high across three queued notes
        send(3, 1, 1, 1, c);
        send(1, 2, 1, 1, c);
        send(5, 1, 1, 0, c);

        // reset in the middle of PLAY
        send(2, 3, 0, 0, c);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_audio", int'(audio_out), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_done", int'(done), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_ready", int'(note_ready), 1);

`ifdef TONE_PLAYER_ABORT_EN
        send(4, 1, 0, 0, c);
        repeat (first_tick(c) + 3) @(negedge clk);
        chk("pre_abort_busy", int'(busy), 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", int'(busy), 0);
        chk("abort_audio", int'(audio_out), 0);
        chk("abort_done", int'(done), 0);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("idle_abort_ready", int'(note_ready), 1);
        chk("idle_abort_busy", int'(busy), 0);
`endif

        send(6, 1, 1, 0, c);
        n = 0;
        while (!note_ready && n < 4000) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        chk("final_idle", int'(note_ready), 1);
        chk("done_count", done_cnt, pushed);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
